// File: rtl/fetch_unit.sv
// fetch_unit: owns the fetch PC, drives the imem req/gnt/rvalid
// handshake and queues fetched instructions toward Decode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] TEXT_LO    = 32'h0000_3000,
  parameter logic [31:0] TEXT_HI    = 32'h0000_6ffc,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter int unsigned DEPTH      = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_req,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic        branch,
  input  logic [31:0] DnPC,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        F_valid,
  input  logic        F_ready,
  output logic [31:0] F_PC,
  output logic [31:0] F_instr,
  output logic [4:0]  exc_code
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE, WAIT, DRAIN, HALT
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  code;
  } ent_t;

  state_t        state;
  logic          run;
  logic [31:0]   fpc;
  logic [31:0]   tag_pc;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  ent_t          q [DEPTH];

  logic          redir;
  logic [31:0]   target;
  logic          legal;
  logic          rsp;
  logic          idle_now;
  logic [CW-1:0] occ;
  logic          space;
  logic          issue;
  logic          err_enq;
  logic          grant;
  logic          enq;
  logic          deq;
  ent_t          enq_ent;

  // Redirect target, PC legality, space and enqueue decisions.
  // A response cycle in WAIT also acts as IDLE so fetches can
  // issue back-to-back; the entry landing this cycle uses space.
  always_comb begin
    redir = exc_req | eret | branch;
    priority case (1'b1)
      exc_req: target = HANDLER_PC;
      eret:    target = epc;
      default: target = DnPC;
    endcase
    legal = (fpc[1:0] == 2'b00) &&
            (fpc >= TEXT_LO) &&
            (fpc <= TEXT_HI);
    rsp      = (state == WAIT) && imem_rvalid;
    idle_now = run && ((state == IDLE) || rsp);
    occ      = count + CW'(rsp);
    space    = occ < CW'(DEPTH);
    issue    = idle_now && space && legal;
    err_enq  = run && (state == IDLE) && space && !legal;
    grant    = issue && imem_gnt;
    enq      = rsp || err_enq;
    enq_ent  = rsp ? {tag_pc, imem_rdata, 5'd0}
                   : {fpc, 32'h0, 5'd4};
    deq      = (count != '0) && F_ready;
  end

  assign imem_req  = issue;
  assign imem_addr = fpc;
  assign F_valid   = (count != '0);
  assign F_PC      = F_valid ? q[rd_ptr].pc    : '0;
  assign F_instr   = F_valid ? q[rd_ptr].instr : '0;
  assign exc_code  = F_valid ? q[rd_ptr].code  : '0;

  // Fetch FSM and PC; a granted request in a redirect cycle is
  // stale and must be drained before fetching the new target.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      run    <= 1'b0;
      fpc    <= RESET_PC;
      tag_pc <= RESET_PC;
    end else begin
      run <= 1'b1;
      if (redir) begin
        fpc <= target;
        if (grant ||
            ((state == WAIT) && !imem_rvalid) ||
            ((state == DRAIN) && !imem_rvalid))
          state <= DRAIN;
        else
          state <= IDLE;
      end else if (grant) begin
        tag_pc <= fpc;
        fpc    <= fpc + 32'd4;
        state  <= WAIT;
      end else if (err_enq) begin
        state <= HALT;
      end else if (rsp) begin
        state <= IDLE;
      end else if ((state == DRAIN) && imem_rvalid) begin
        state <= IDLE;
      end
    end
  end

  // Queue pointers and occupancy; a redirect empties the queue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redir) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + AW'(1);
      if (deq) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(enq) - CW'(deq);
    end
  end

  // Queue storage; contents are only visible while F_valid.
  always_ff @(posedge clk) begin
    if (enq && !redir) q[wr_ptr] <= enq_ent;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: random and directed stimulus with a redirect
// scoreboard and a behavioural memory responder.
module tb_fetch_unit;

  localparam logic [31:0] RST = 32'h0000_3000;
  localparam logic [31:0] LO  = 32'h0000_3000;
  localparam logic [31:0] HI  = 32'h0000_6ffc;
  localparam logic [31:0] HND = 32'h0000_4180;

  logic        clk = 1'b0;
  logic        reset;
  logic        exc_req, eret, branch;
  logic [31:0] epc, DnPC;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt, imem_rvalid;
  logic [31:0] imem_rdata;
  logic        F_valid, F_ready;
  logic [31:0] F_PC, F_instr;
  logic [4:0]  exc_code;

  int n_chk = 0;
  int n_fail = 0;

  bit zero_wait = 1;
  bit stall_rv = 0;

  logic [31:0] tq[$];
  logic [31:0] exp_pc = RST;
  bit          seg_done = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .reset(reset),
    .exc_req(exc_req), .eret(eret), .epc(epc),
    .branch(branch), .DnPC(DnPC),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .F_valid(F_valid), .F_ready(F_ready),
    .F_PC(F_PC), .F_instr(F_instr), .exc_code(exc_code)
  );

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
  endfunction

  function automatic bit legal_f(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a >= LO) && (a <= HI);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #3;
  endtask

  // memory: rvalid at +0, gnt at +1, handshake recorded at +2
  initial begin
    bit has_pend;
    logic [31:0] pend_addr;
    int pend_wait;
    has_pend = 0; pend_addr = '0; pend_wait = 0;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
    forever begin
      @(negedge clk);
      if (has_pend && !stall_rv && pend_wait == 0) begin
        imem_rvalid = 1;
        imem_rdata = mem_f(pend_addr);
        has_pend = 0;
      end else begin
        imem_rvalid = 0;
        imem_rdata = $urandom;
        if (has_pend && !stall_rv) pend_wait--;
      end
      #1;
      imem_gnt = !has_pend &&
                 (zero_wait || $urandom_range(0, 2) != 0);
      #1;
      if (imem_req && imem_gnt && reset) begin
        has_pend = 1;
        pend_addr = imem_addr;
        pend_wait = zero_wait ? 0 : int'($urandom_range(0, 2));
      end
    end
  end

  // scoreboard: each redirect starts a new expected PC stream
  always @(negedge clk) begin
    #4;
    if (!reset) begin
      exp_pc = RST;
      seg_done = 0;
      tq.delete();
    end else begin
      if (F_valid && F_ready) begin
        if (seg_done) begin
          n_chk++; n_fail++;
          $display("FAIL sb_extra: got F_PC %h required no entry after AdEL",
                   F_PC);
        end else begin
          chk("sb F_PC", F_PC, exp_pc);
          chk("sb F_instr", F_instr,
              legal_f(exp_pc) ? mem_f(exp_pc) : 32'h0);
          chk("sb exc_code", 32'(exc_code),
              legal_f(exp_pc) ? 32'd0 : 32'd4);
          seg_done = !legal_f(exp_pc);
          exp_pc = exp_pc + 32'd4;
        end
      end
      if (exc_req || eret || branch) begin
        if (tq.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL sb_redirect: got redirect required queued target");
        end else begin
          exp_pc = tq.pop_front();
          seg_done = 0;
        end
      end
      if (imem_req && imem_gnt)
        chk("req addr legal", 32'(legal_f(imem_addr)), 32'd1);
    end
  end

  task automatic do_redirect(input bit e, input bit r, input bit b,
                             input logic [31:0] ep,
                             input logic [31:0] dn);
    exc_req = e; eret = r; branch = b; epc = ep; DnPC = dn;
    tq.push_back(e ? HND : (r ? ep : dn));
    cyc();
    exc_req = 0; eret = 0; branch = 0;
  endtask

  task automatic wait_valid(input string nm);
    bit ok;
    ok = 0;
    for (int k = 0; k < 100; k++) begin
      if (F_valid) begin ok = 1; break; end
      cyc();
    end
    if (!ok) begin
      n_chk++; n_fail++;
      $display("FAIL %s: got no F_valid in 100 cycles required F_valid", nm);
    end
  endtask

  task automatic wait_grant(input logic [31:0] a, input string nm);
    bit ok;
    ok = 0;
    for (int k = 0; k < 100; k++) begin
      cyc();
      if (imem_req && imem_gnt && imem_addr == a) begin
        ok = 1; break;
      end
    end
    if (!ok) begin
      n_chk++; n_fail++;
      $display("FAIL %s: got no grant in 100 cycles required grant at %h",
               nm, a);
    end
  endtask

  task automatic watch_err(input logic [31:0] pc, input bit no_req,
                           input string nm);
    int nreq;
    bit seen;
    nreq = 0; seen = 0;
    for (int k = 0; k < 12; k++) begin
      cyc();
      if (imem_req) nreq++;
      if (F_valid && F_PC == pc && F_instr == 0 && exc_code == 5'd4)
        seen = 1;
    end
    if (no_req) chk({nm, " imem_req cycles"}, nreq, 0);
    chk({nm, " AdEL entry"}, 32'(seen), 32'd1);
  endtask

  task automatic pulse_reset();
    reset = 0;
    cyc();
    reset = 1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ngr;
    int ntx;
    logic [31:0] t;
    reset = 0; exc_req = 0; eret = 0; branch = 0;
    epc = '0; DnPC = '0; F_ready = 0;
    repeat (2) cyc();
    chk("rst F_valid", 32'(F_valid), 0);
    chk("rst F_PC", F_PC, 0);
    chk("rst F_instr", F_instr, 0);
    chk("rst exc_code", 32'(exc_code), 0);
    chk("rst imem_req", 32'(imem_req), 0);
    chk("rst imem_addr", imem_addr, RST);
    reset = 1;
    #1;
    chk("rel imem_req", 32'(imem_req), 0);
    chk("rel imem_addr", imem_addr, RST);
    chk("rel F_valid", 32'(F_valid), 0);

    // zero-wait streaming, one instruction per cycle
    F_ready = 1;
    wait_valid("stream start");
    for (int i = 0; i < 8; i++) begin
      chk("stream F_valid", 32'(F_valid), 1);
      chk("stream F_PC", F_PC, RST + 32'(4 * i));
      chk("stream exc_code", 32'(exc_code), 0);
      cyc();
    end

    // Decode stalled: exactly DEPTH entries then no requests
    F_ready = 0;
    pulse_reset();
    ngr = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (imem_req && imem_gnt) ngr++;
    end
    chk("full grants", ngr, 4);
    chk("full imem_req", 32'(imem_req), 0);
    chk("full F_valid", 32'(F_valid), 1);
    chk("full head", F_PC, RST);
    F_ready = 1;
    for (int i = 0; i < 4; i++) begin
      chk("drain F_PC", F_PC, RST + 32'(4 * i));
      cyc();
    end

    // branch while 0x3010 is outstanding with entries queued
    pulse_reset();
    wait_grant(32'h300c, "br 300c");
    F_ready = 0;
    wait_grant(32'h3010, "br 3010");
    stall_rv = 1;
    cyc();
    do_redirect(0, 0, 1, 32'h0, 32'h3400);
    stall_rv = 0;
    F_ready = 1;
    wait_valid("br target");
    chk("br F_PC", F_PC, 32'h3400);

    // misaligned and out-of-range targets, then eret resumes
    do_redirect(0, 0, 1, 32'h0, 32'h3002);
    watch_err(32'h3002, 1, "mis");
    do_redirect(0, 0, 1, 32'h0, 32'h7000);
    watch_err(32'h7000, 1, "oor");
    do_redirect(0, 1, 0, 32'h3000, 32'h0);
    wait_valid("eret");
    chk("eret F_PC", F_PC, 32'h3000);

    // top of text: 6ff8, 6ffc then AdEL at 7000
    do_redirect(0, 0, 1, 32'h0, 32'h6ff8);
    watch_err(32'h7000, 0, "top");

    // all redirects together: exception wins
    do_redirect(1, 1, 1, 32'h5000, 32'h3400);
    wait_valid("prio");
    chk("prio F_PC", F_PC, HND);

    // reset mid-WAIT with three entries queued
    F_ready = 0;
    pulse_reset();
    wait_grant(32'h300c, "mid 300c");
    stall_rv = 1;
    cyc();
    chk("mid F_valid", 32'(F_valid), 1);
    reset = 0;
    #1;
    chk("mid rst F_valid", 32'(F_valid), 0);
    chk("mid rst F_PC", F_PC, 0);
    chk("mid rst F_instr", F_instr, 0);
    chk("mid rst imem_req", 32'(imem_req), 0);
    chk("mid rst imem_addr", imem_addr, RST);
    cyc();
    cyc();
    reset = 1;
    #1;
    chk("mid rel imem_req", 32'(imem_req), 0);
    stall_rv = 0;
    F_ready = 1;
    wait_valid("mid restart");
    chk("mid F_PC", F_PC, RST);
    chk("mid F_instr", F_instr, mem_f(RST));

    // random traffic: wait states, stalls, redirects
    zero_wait = 0;
    ntx = 0;
    for (int i = 0; i < 3000; i++) begin
      F_ready = ($urandom_range(0, 3) != 0);
      if (F_valid && F_ready) ntx++;
      if ($urandom_range(0, 39) == 0) begin
        case ($urandom_range(0, 4))
          0: t = 32'h6fe0 + 32'(4 * $urandom_range(0, 7));
          1: t = 32'h3000 + 32'($urandom_range(0, 255));
          2: t = 32'h2ff8 + 32'(4 * $urandom_range(0, 1));
          default: t = 32'h3000 + 32'(4 * $urandom_range(0, 255));
        endcase
        case ($urandom_range(0, 2))
          0: do_redirect(1, $urandom_range(0, 1) == 1,
                         $urandom_range(0, 1) == 1, t, t + 32'd8);
          1: do_redirect(0, 1, $urandom_range(0, 1) == 1,
                         t, 32'h3100);
          default: do_redirect(0, 0, 1, 32'h0, t);
        endcase
      end else begin
        cyc();
      end
    end
    chk("random progress", 32'(ntx > 300), 32'd1);
    F_ready = 1;
    repeat (10) cyc();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised fetch stage that owns the fetch PC, issues instruction-memory requests through a req/gnt/rvalid handshake, and buffers fetched instructions in a DEPTH-entry queue toward Decode. It handles redirects from branch resolution, exception entry and `eret`. It range- and alignment-checks every PC and raises AdEL (exc_code 4) without touching memory. It sits between the PC source logic and the F/D pipeline register, and replaces the single-register, pause-driven fetch.

## Interface
- RESET_PC, 32'h0000_3000, PC loaded at reset
- TEXT_LO, 32'h0000_3000, lowest legal fetch address
- TEXT_HI, 32'h0000_6ffc, highest legal fetch address (inclusive)
- HANDLER_PC, 32'h0000_4180, exception entry address
- DEPTH, 4, instruction queue entries (power of 2, ≥2)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- exc_req  in  1  take exception; redirect to HANDLER_PC
- eret  in  1  return from exception; redirect to epc
- epc  in  32  eret target
- branch  in  1  branch/jump taken; redirect to DnPC
- DnPC  in  32  branch target
- imem_req  out  1  memory request valid
- imem_addr  out  32  request address (= fpc)
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  response data valid
- imem_rdata  in  32  response instruction
- F_valid  out  1  queue head valid
- F_ready  in  1  Decode accepts head
- F_PC  out  32  head PC (0 when empty)
- F_instr  out  32  head instruction (0 when empty)
- exc_code  out  5  head exception code: 0 none, 4 AdEL

## Operation
- Legal PC: fpc[1:0]==0 and TEXT_LO ≤ fpc ≤ TEXT_HI (unsigned, 32-bit compare).
- Space rule: a fetch is started only if count + outstanding < DEPTH. At most one request is outstanding.
- FSM states are IDLE, WAIT, DRAIN and HALT.
  - IDLE, space, fpc legal: imem_req=1. On imem_gnt, record tag_pc=fpc, fpc←fpc+4, go to WAIT.
  - IDLE, space, fpc illegal: enqueue {fpc, 32'h0, 5'd4} without a memory access, then go to HALT.
  - WAIT: on imem_rvalid, enqueue {tag_pc, imem_rdata, 0} and go to IDLE. The IDLE rules also apply in that same cycle, so a new request may issue back-to-back. Space for that request counts the entry just enqueued.
  - HALT: no requests. Leave only on a redirect.
  - DRAIN: no requests. On imem_rvalid, discard the data and go to IDLE.
- Redirect priority: exc_req > eret > branch. On any redirect:
  - The queue is flushed (count←0).
  - fpc←target.
  - WAIT→DRAIN, HALT→IDLE, DRAIN stays DRAIN.
  - Any gnt or enqueue in the redirect cycle is ignored. If imem_gnt is high in the redirect cycle, the granted request becomes stale and the FSM goes to DRAIN.
- Dequeue: when F_valid && F_ready, the head pops. A dequeue in a redirect cycle still counts as transferred. The queue is empty the next cycle.
- Full queue: F_valid stays high and no new request issues. Simultaneous enqueue and dequeue keeps count unchanged.
- Pointers wrap modulo DEPTH. Count width is clog2(DEPTH)+1.

## Timing
- During reset and in the first cycle after release:
  - fpc=RESET_PC, FSM=IDLE, count=0.
  - F_valid=0, F_PC=0, F_instr=0, exc_code=0.
  - imem_req=0, imem_addr=RESET_PC.
- Reset asserted mid-transaction discards outstanding and queued state immediately. A late imem_rvalid arriving after reset release while in IDLE is ignored.
- imem_req is asserted from IDLE combinationally. imem_addr holds stable until gnt. imem_gnt may arrive in the same cycle as the request.
- imem_rvalid arrives no earlier than the cycle after gnt.
- An enqueued entry appears at F_valid the cycle after the enqueue edge. Best-case sustained rate is one instruction per cycle, with gnt same-cycle and rvalid one cycle later.
- Redirect to request: the target appears on imem_req/imem_addr the cycle after the redirect, or after the stale response drains.

## Test plan
- Reset then zero-wait memory (gnt same cycle, rvalid +1), F_ready=1:
  - F_PC sequence is 3000, 3004, 3008… on consecutive cycles after the 2-cycle startup.
  - exc_code stays 0.
- F_ready=0 for 10 cycles: exactly DEPTH=4 entries (3000–300c) are queued and imem_req drops. Raising F_ready drains them in order with no loss or duplicate.
- branch=1, DnPC=0x3400 while a request for 0x3010 is in WAIT:
  - The 0x3010 response is discarded.
  - The next F_PC is 0x3400.
  - Entries queued before the branch never reach Decode.
- DnPC=0x3002, then separately DnPC=0x7000: one entry with exc_code=4 and F_instr=0 appears at that PC, and no imem_req is issued. A later eret with epc=0x3000 resumes fetching.
- exc_req, eret and branch asserted together: the next fetch address is 0x4180.
- reset pulled low mid-WAIT with 3 entries queued:
  - Outputs return to reset values immediately.
  - After release, fetch restarts at 0x3000.
